sram_bist: RTL and testbench

//  Initiator for the single-port SRAM interface (ADDR/DI/EN/WE in, DO out).
//  On a start pulse, writes a deterministic pattern to every address from 0 to LAST_ADDR.
//  It then reads every address back, compares each word and reports pass/fail.

---
 rtl/sram_bist_pkg.sv | 16 +
 rtl/sram_bist_if.sv | 16 +
 rtl/sram_bist.sv | 176 +++++++++++++++++
 tb/tb_sram_bist.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_bist_pkg.sv
// Shared definitions for the SRAM built-in self-test engine.
package sram_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_PASS  = 3'd4,
    ST_FAIL  = 3'd5
  } state_e;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 2 * DEF_ADDR_W;

endpackage

// File: rtl/sram_bist_if.sv
// Single-port SRAM bus: the BIST drives ADDR/DI/EN/WE, the SRAM returns DO.
interface sram_bist_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);

  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] DI;
  logic [DATA_W-1:0] DO;
  logic              EN;
  logic              WE;

  modport master (output ADDR, output DI, output EN, output WE, input DO);
  modport slave  (input ADDR, input DI, input EN, input WE, output DO);

endinterface

// File: rtl/sram_bist.sv
// Memory self-test: writes pat(a) = {~a, a} to every address, reads it all back,
// and reports the first mismatching address and the data seen there.
module sram_bist
  import sram_bist_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned LAST_ADDR = (2 ** ADDR_W) - 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  sram_bist_if.master       sram
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(LAST_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LAST_ADDR);

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    return DATA_W'({~a, a});
  endfunction

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] fail_data_q, fail_data_d;
  logic              en_q, en_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] di_q, di_d;
  logic              chk_valid_q, chk_valid_d;
  logic [ADDR_W-1:0] chk_addr_q, chk_addr_d;
  logic              mismatch;

  // chk_* mirrors the read the SRAM samples this edge, so DO is compared one cycle later
  assign mismatch = chk_valid_q && (sram.DO != pat(chk_addr_q));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    en_d        = en_q;
    we_d        = we_q;
    addr_d      = addr_q;
    di_d        = di_q;
    chk_valid_d = en_q & ~we_q;
    chk_addr_d  = addr_q;

    case (state_q)
      ST_IDLE, ST_PASS, ST_FAIL: begin
        en_d = 1'b0;
        if (start) begin
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          fail_addr_d = '0;
          fail_data_d = '0;
          en_d        = 1'b1;
          we_d        = 1'b1;
          addr_d      = '0;
          di_d        = pat('0);
          if (LAST_ADDR == 0) begin
            state_d = ST_READ;
            cnt_d   = '0;
          end else begin
            state_d = ST_WRITE;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ST_WRITE: begin
        en_d   = 1'b1;
        we_d   = 1'b1;
        addr_d = ADDR_W'(cnt_q);
        di_d   = pat(ADDR_W'(cnt_q));
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_READ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_READ: begin
        en_d   = 1'b1;
        we_d   = 1'b0;
        addr_d = ADDR_W'(cnt_q);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        en_d = 1'b0;
        if (chk_valid_q && !mismatch && (chk_addr_q == ADDR_LAST)) begin
          state_d = ST_PASS;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        en_d    = 1'b0;
      end
    endcase

    // First mismatch wins; the read issued this cycle is dropped
    if (((state_q == ST_READ) || (state_q == ST_DRAIN)) && mismatch) begin
      state_d     = ST_FAIL;
      en_d        = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b1;
      pass_d      = 1'b0;
      fail_addr_d = chk_addr_q;
      fail_data_d = sram.DO;
      chk_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      en_q        <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      di_q        <= '0;
      chk_valid_q <= 1'b0;
      chk_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      en_q        <= en_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      di_q        <= di_d;
      chk_valid_q <= chk_valid_d;
      chk_addr_q  <= chk_addr_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign sram.ADDR = addr_q;
  assign sram.DI   = di_q;
  assign sram.EN   = en_q;
  assign sram.WE   = we_q;

endmodule

// File: tb/tb_sram_bist.sv
// Bench for sram_bist: 16-word SRAM model with read corruption, plus a full-size
// instance used only to spot-check the write pattern deep in the address space.
module tb_sram_bist;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned LA = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, busy, done, pass;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;

  logic          reset2, start2, busy2, done2, pass2;
  logic [AW-1:0] fail_addr2;
  logic [DW-1:0] fail_data2;

  sram_bist_if #(.ADDR_W(AW), .DATA_W(DW)) sram ();
  sram_bist_if #(.ADDR_W(AW), .DATA_W(DW)) sram2 ();

  sram_bist #(.ADDR_W(AW), .DATA_W(DW), .LAST_ADDR(LA)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_data(fail_data), .sram(sram)
  );

  sram_bist #(.ADDR_W(AW), .DATA_W(DW), .LAST_ADDR(65535)) dut_full (
    .clk(clk), .reset(reset2), .start(start2), .busy(busy2), .done(done2), .pass(pass2),
    .fail_addr(fail_addr2), .fail_data(fail_data2), .sram(sram2)
  );

  assign sram2.DO = '0;

  // SRAM model; corrupt[a] makes reads of address a return zero
  logic [DW-1:0] mem [16];
  logic [15:0]   corrupt;
  logic [3:0]    a4;
  assign a4 = 4'(sram.ADDR);
  always @(posedge clk) begin
    if (sram.EN) begin
      if (sram.WE) mem[a4] <= sram.DI;
      else         sram.DO <= corrupt[a4] ? '0 : mem[a4];
    end
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Start at edge 0; return the first edge after which done is seen (-1 on timeout)
  task automatic run(input int restart, output int got_edge, output bit busy_ok);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    busy_ok  = busy;
    got_edge = -1;
    for (int k = 1; k <= 60 && got_edge < 0; k++) begin
      start = (k == restart);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (done) got_edge = k;
      else if (!busy) busy_ok = 1'b0;
    end
  endtask

  typedef struct {
    string       name;
    logic [15:0] mask;
    int          restart;
    int          done_edge;
    logic        exp_pass;
    logic [15:0] exp_fa;
    logic [31:0] exp_fd;
  } vec_t;

  vec_t vecs [6];

  task automatic check_result(input vec_t v, input int got_edge, input bit busy_ok);
    chk({v.name, "_done_edge"}, 32'(got_edge), 32'(v.done_edge));
    chk({v.name, "_busy_during"}, 32'(busy_ok), 32'd1);
    chk({v.name, "_busy_end"}, 32'(busy), 32'd0);
    chk({v.name, "_pass"}, 32'(pass), 32'(v.exp_pass));
    chk({v.name, "_en_off"}, 32'(sram.EN), 32'd0);
    if (!v.exp_pass) begin
      chk({v.name, "_fail_addr"}, 32'(fail_addr), 32'(v.exp_fa));
      chk({v.name, "_fail_data"}, fail_data, v.exp_fd);
    end
    repeat (3) @(negedge clk);
    chk({v.name, "_done_hold"}, 32'(done), 32'd1);
    chk({v.name, "_en_hold"}, 32'(sram.EN), 32'd0);
  endtask

  initial begin
    int  got_edge;
    bit  busy_ok;
    int  k;
    vec_t v;

    reset   = 1'b1;
    start   = 1'b0;
    reset2  = 1'b1;
    start2  = 1'b0;
    corrupt = '0;

    vecs[0] = '{"clean",        16'h0000,  0, 33, 1'b1, 16'd0,  32'h0};
    vecs[1] = '{"bad5",         16'h0020,  0, 23, 1'b0, 16'd5,  32'h0};
    vecs[2] = '{"bad2_and_9",   16'h0204,  0, 20, 1'b0, 16'd2,  32'h0};
    vecs[3] = '{"start_ignored",16'h0000, 10, 33, 1'b1, 16'd0,  32'h0};
    vecs[4] = '{"bad_last",     16'h8000,  0, 33, 1'b0, 16'd15, 32'h0};
    vecs[5] = '{"bad_first",    16'h0001,  0, 18, 1'b0, 16'd0,  32'h0};

    // Reset state
    do_reset();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_fail_addr", 32'(fail_addr), 32'd0);
    chk("rst_fail_data", fail_data, 32'd0);
    chk("rst_en", 32'(sram.EN), 32'd0);
    chk("rst_we", 32'(sram.WE), 32'd0);
    chk("rst_addr", 32'(sram.ADDR), 32'd0);
    chk("rst_di", sram.DI, 32'd0);

    // Bus waveform: first write, a middle write, first read with DI held
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("w0_en", 32'(sram.EN), 32'd1);
    chk("w0_we", 32'(sram.WE), 32'd1);
    chk("w0_addr", 32'(sram.ADDR), 32'd0);
    chk("w0_di", sram.DI, 32'hFFFF_0000);
    repeat (3) @(negedge clk);
    chk("w3_addr", 32'(sram.ADDR), 32'd3);
    chk("w3_di", sram.DI, 32'hFFFC_0003);
    repeat (13) @(negedge clk);
    chk("r0_we", 32'(sram.WE), 32'd0);
    chk("r0_addr", 32'(sram.ADDR), 32'd0);
    chk("r0_di_held", sram.DI, 32'hFFF0_000F);
    k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("wave_pass", 32'(pass), 32'd1);

    // Table of full runs
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      do_reset();
      corrupt = v.mask;
      run(v.restart, got_edge, busy_ok);
      check_result(v, got_edge, busy_ok);
    end

    // Reset in the middle of the read phase, then a clean rerun
    do_reset();
    corrupt = '0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_en", 32'(sram.EN), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    reset = 1'b0;
    v = '{"after_reset", 16'h0000, 0, 33, 1'b1, 16'd0, 32'h0};
    run(0, got_edge, busy_ok);
    check_result(v, got_edge, busy_ok);

    // Full-size instance: write of 16'hABCD is issued after edge 43981
    @(negedge clk);
    reset2 = 1'b0;
    start2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start2 = 1'b0;
    k = 0;
    while (!(sram2.EN && sram2.WE && sram2.ADDR == 16'hABCD) && k < 50000) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    chk("full_abcd_edge", 32'(k), 32'd43981);
    chk("full_abcd_di", sram2.DI, 32'h5432_ABCD);
    chk("full_busy", 32'(busy2), 32'd1);
    chk("full_done", 32'(done2), 32'd0);
    chk("full_pass", 32'(pass2), 32'd0);
    chk("full_fail_addr", 32'(fail_addr2), 32'd0);
    chk("full_fail_data", fail_data2, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
